shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Parametrised, pipelined ARM operand-2 barrel shifter with carry-out generation and valid/ready flow control. It sits between register-file read and the ALU. It accepts one shift request per cycle and implements full ARM shift semantics: immediate rotate, immediate or register shift amounts, the amount-0 special encodings, and amounts at or above the width. Results and the shifter carry-out leave after a configurable number of pipeline stages, and the pipeline stalls cleanly under downstream backpressure.

## Interface
- WIDTH, 32, operand width; power of 2, 8..128
- PIPE_STAGES, 2, register stages from input to output; legal values 1 or 2
- IMM_W, 8, width of the immediate field, zero-extended to WIDTH
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  block accepts the request this cycle
- in_data  in  WIDTH  Rm operand
- in_carry  in  1  current C flag
- in_imm_op  in  1  1 selects the immediate-rotate path
- in_imm  in  IMM_W  immediate value
- in_rot  in  4  rotate field; rotate amount is 2*in_rot
- in_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- in_reg_amt  in  1  1 takes the amount from in_amt_reg
- in_amt_imm  in  log2(WIDTH)  immediate shift amount
- in_amt_reg  in  8  Rs[7:0]
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  shifted operand
- out_carry  out  1  shifter carry-out

## Operation
Notation: W = WIDTH, D = in_data, C = in_carry.

- **Transfer rule.** A request transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- **Immediate path (in_imm_op=1).**
  - out_data = zext(in_imm) rotated right by (2*in_rot) mod W.
  - out_carry = C if in_rot==0, else out_data[W-1].
  - The in_type and amount fields are ignored.
- **Immediate amount (in_reg_amt=0)**, a = in_amt_imm:
  - LSL: a=0 gives D and carry C; otherwise D<<a and carry D[W-a].
  - LSR: a=0 encodes W, giving 0 and carry D[W-1]; otherwise D>>a (zero fill) and carry D[a-1].
  - ASR: a=0 encodes W, giving all bits = D[W-1] and carry D[W-1]; otherwise sign-filled D>>a and carry D[a-1].
  - ROR: a=0 is RRX, giving {C, D[W-1:1]} and carry D[0]; otherwise D rotated right by a and carry D[a-1].
- **Register amount (in_reg_amt=1)**, r = in_amt_reg as unsigned 8-bit:
  - r=0 for any type: D and carry C.
  - LSL: r<W gives the normal result; r==W gives 0 with carry D[0]; r>W gives 0 with carry 0.
  - LSR: r<W gives the normal result; r==W gives 0 with carry D[W-1]; r>W gives 0 with carry 0.
  - ASR: r>=W gives all bits = D[W-1] and carry D[W-1].
  - ROR: let m = r mod W. m=0 gives D with carry D[W-1]; otherwise rotate right by m with carry D[m-1].
- **Pipeline split.**
  - PIPE_STAGES=2: stage 1 registers the decoded effective amount, fill mode and carry selection; stage 2 performs the shift and registers the outputs.
  - PIPE_STAGES=1: everything is computed combinationally into the single output register.
- **Elastic pipeline.**
  - Each stage holds a valid bit.
  - A stage loads when it is empty or its contents advance in the same cycle.
  - in_ready = !stage1_valid || stage1 advances, evaluated combinationally from out_ready.
  - Bubbles collapse.
  - No request is dropped or duplicated.

## Timing
- **Reset.** While reset=1 at a clock edge, all stage valid bits clear.
  - out_valid=0, out_data=0 and out_carry=0 from the following cycle.
  - in_ready=0 while reset is high.
  - A request presented during reset is discarded.
  - Reset mid-stall flushes all in-flight results.
- **Latency.** A request accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1 when unstalled: same cycle as the register update for PIPE_STAGES=1, next edge for PIPE_STAGES=2.
- **Throughput.** One request per cycle while out_ready=1.
- **Backpressure.** While out_valid && !out_ready, out_data and out_carry are held bit-stable. The pipeline fills, then in_ready drops.
  - PIPE_STAGES=2 buffers 2 results.
  - PIPE_STAGES=1 buffers 1 result.
- **Simultaneous events.** With the pipeline full and out_ready=1, a new request is accepted in the same cycle the output drains (in_ready=1).
- **Boundaries.**
  - Amount fields are interpreted exactly as listed; no value produces X.
  - Amounts 1..W-1 for LSL/LSR/ASR/ROR must use the same datapath for every legal WIDTH.

## Test plan
- **Reset.** W=32: assert reset for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_carry=0, in_ready=0; no result ever emerges for those requests.
- **Immediate path.** in_imm_op=1, in_imm=0xFF, in_rot=4, C=0 -> out_data=0xFF000000, out_carry=1. Same with in_rot=0, C=1 -> out_data=0x000000FF, out_carry=1.
- **Amount-0 encodings.** D=0x80000001, C=1, in_reg_amt=0, a=0:
  - LSR -> 0x00000000, carry 1.
  - ASR -> 0xFFFFFFFF, carry 1.
  - ROR (RRX) -> 0xC0000000, carry 1.
  - LSL -> 0x80000001, carry 1.
- **Register amounts.** D=0x00000003, C=0:
  - LSL r=32 -> 0, carry 1.
  - LSL r=33 -> 0, carry 0.
  - ROR r=33 -> 0x80000001, carry 1.
  - ROR r=64 -> 0x00000003, carry 0.
  - LSL r=0 with C=1 -> 0x00000003, carry 1.
- **Backpressure.** PIPE_STAGES=2, stream 5 requests back-to-back with out_ready held 0 for cycles 3-6 -> in_ready drops after 2 accepts; outputs held stable; all 5 results emerge in order with correct values, none lost or duplicated.
- **Width sweep.** Random stimulus at WIDTH=8, 32 and 64, PIPE_STAGES=1 and 2, against a reference model -> every out_data/out_carry matches, and latency equals PIPE_STAGES with out_ready=1.

Source files
------------

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined ARM operand-2 barrel shifter with
// carry-out generation and valid/ready flow control.
module shifter_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int IMM_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_carry,
    input  logic                       in_imm_op,
    input  logic [IMM_W-1:0]           in_imm,
    input  logic [3:0]                 in_rot,
    input  logic [1:0]                 in_type,
    input  logic                       in_reg_amt,
    input  logic [$clog2(WIDTH)-1:0]   in_amt_imm,
    input  logic [7:0]                 in_amt_reg,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_carry
);
    localparam int AW = $clog2(WIDTH);
    localparam int YW = WIDTH + 1;

    typedef enum logic [1:0] {F_ZERO, F_SIGN, F_ROT, F_CIN} fill_e;
    typedef enum logic [1:0] {O_NONE, O_ZERO, O_SIGN} ovr_e;
    typedef enum logic [2:0] {
        C_IN, C_SHIFT, C_ZERO, C_DMSB, C_DLSB, C_RMSB
    } csel_e;

    typedef struct packed {
        logic [WIDTH-1:0] src;
        logic [AW-1:0]    amt;
        logic             left;
        fill_e            fill;
        logic             cin;
        ovr_e             ovr;
        csel_e            csel;
    } dec_t;

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] o;
        for (int i = 0; i < WIDTH; i++) o[i] = v[WIDTH-1-i];
        return o;
    endfunction

    dec_t       dec;
    logic [8:0] r9;
    logic [7:0] rot2;

    assign r9   = {1'b0, in_amt_reg};
    assign rot2 = {3'b000, in_rot, 1'b0};

    // Decode: effective amount, fill mode, overrides and carry source
    always_comb begin
        dec.src  = in_data;
        dec.amt  = in_amt_imm;
        dec.left = 1'b0;
        dec.fill = F_ZERO;
        dec.cin  = in_carry;
        dec.ovr  = O_NONE;
        dec.csel = C_SHIFT;
        if (in_imm_op) begin
            dec.src  = WIDTH'(in_imm);
            dec.amt  = rot2[AW-1:0];
            dec.fill = F_ROT;
            dec.csel = (in_rot == 4'd0) ? C_IN : C_RMSB;
        end else if (!in_reg_amt) begin
            unique case (in_type)
                2'b00: begin
                    dec.left = 1'b1;
                    if (in_amt_imm == '0) dec.csel = C_IN;
                end
                2'b01: begin
                    if (in_amt_imm == '0) begin
                        dec.ovr  = O_ZERO;
                        dec.csel = C_DMSB;
                    end
                end
                2'b10: begin
                    dec.fill = F_SIGN;
                    if (in_amt_imm == '0) begin
                        dec.ovr  = O_SIGN;
                        dec.csel = C_DMSB;
                    end
                end
                default: begin
                    dec.fill = F_ROT;
                    if (in_amt_imm == '0) begin
                        dec.fill = F_CIN;
                        dec.amt  = AW'(1);
                    end
                end
            endcase
        end else begin
            dec.amt = in_amt_reg[AW-1:0];
            if (in_amt_reg == 8'd0) begin
                dec.csel = C_IN;
            end else begin
                unique case (in_type)
                    2'b00: begin
                        dec.left = 1'b1;
                        if (r9 == 9'(WIDTH)) begin
                            dec.ovr  = O_ZERO;
                            dec.csel = C_DLSB;
                        end else if (r9 > 9'(WIDTH)) begin
                            dec.ovr  = O_ZERO;
                            dec.csel = C_ZERO;
                        end
                    end
                    2'b01: begin
                        if (r9 == 9'(WIDTH)) begin
                            dec.ovr  = O_ZERO;
                            dec.csel = C_DMSB;
                        end else if (r9 > 9'(WIDTH)) begin
                            dec.ovr  = O_ZERO;
                            dec.csel = C_ZERO;
                        end
                    end
                    2'b10: begin
                        dec.fill = F_SIGN;
                        if (r9 >= 9'(WIDTH)) begin
                            dec.ovr  = O_SIGN;
                            dec.csel = C_DMSB;
                        end
                    end
                    default: begin
                        dec.fill = F_ROT;
                        if (in_amt_reg[AW-1:0] == '0) dec.csel = C_DMSB;
                    end
                endcase
            end
        end
    end

    dec_t             st;
    logic             st_v;
    logic             s2_en;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] fillv;
    logic [WIDTH-1:0] sres;
    logic [WIDTH-1:0] res;
    logic [YW-1:0]    y;
    logic             carry;

    assign s2_en = !out_valid || out_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_two
            dec_t s1_q;
            logic s1_v;

            assign in_ready = !reset && (!s1_v || s2_en);
            assign st       = s1_q;
            assign st_v     = s1_v;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_v <= 1'b0;
                    s1_q <= '0;
                end else if (!s1_v || s2_en) begin
                    s1_v <= in_valid;
                    if (in_valid) s1_q <= dec;
                end
            end
        end else begin : g_one
            assign in_ready = !reset && s2_en;
            assign st       = dec;
            assign st_v     = in_valid;
        end
    endgenerate

    // One right-shifter serves every type; LSL runs it on the
    // bit-reversed operand, and the extra LSB catches the carry.
    always_comb begin
        opnd = st.left ? rev(st.src) : st.src;
        unique case (st.fill)
            F_ZERO:  fillv = '0;
            F_SIGN:  fillv = {WIDTH{st.src[WIDTH-1]}};
            F_ROT:   fillv = opnd;
            default: fillv = {WIDTH{st.cin}};
        endcase
        y    = YW'({fillv, opnd, 1'b0} >> st.amt);
        sres = y[WIDTH:1];
        res  = st.left ? rev(sres) : sres;
        case (st.ovr)
            O_ZERO:  res = '0;
            O_SIGN:  res = {WIDTH{st.src[WIDTH-1]}};
            default: ;
        endcase
        unique case (st.csel)
            C_IN:    carry = st.cin;
            C_SHIFT: carry = y[0];
            C_ZERO:  carry = 1'b0;
            C_DMSB:  carry = st.src[WIDTH-1];
            C_DLSB:  carry = st.src[0];
            default: carry = res[WIDTH-1];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else if (s2_en) begin
            out_valid <= st_v;
            if (st_v) begin
                out_data  <= res;
                out_carry <= carry;
            end
        end
    end
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed and randomised checks of shifter_pipe
// across WIDTH 8/32/64 and PIPE_STAGES 1/2.
module tb_shifter_pipe;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] d;
    logic         c;
    logic         immop;
    logic [7:0]   imm;
    logic [3:0]   rot;
    logic [1:0]   typ;
    logic         rega;
    logic [7:0]   ai;
    logic [7:0]   r;

    logic [5:0]   ir;
    logic [5:0]   ov;
    logic [5:0]   oc;
    logic [127:0] od [6];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int W = (g < 2) ? 32 : (g < 4) ? 8 : 64;
        localparam int P = (g % 2 == 0) ? 2 : 1;
        logic [W-1:0] o_d;
        shifter_pipe #(.WIDTH(W), .PIPE_STAGES(P), .IMM_W(8)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_ready   (ir[g]),
            .in_data    (d[W-1:0]),
            .in_carry   (c),
            .in_imm_op  (immop),
            .in_imm     (imm),
            .in_rot     (rot),
            .in_type    (typ),
            .in_reg_amt (rega),
            .in_amt_imm (ai[$clog2(W)-1:0]),
            .in_amt_reg (r),
            .out_valid  (ov[g]),
            .out_ready  (out_ready),
            .out_data   (o_d),
            .out_carry  (oc[g])
        );
        assign od[g] = 128'(o_d);
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic io, input logic [7:0] im,
                          input logic [3:0] ro, input logic [1:0] ty,
                          input logic ra, input logic [7:0] a,
                          input logic [7:0] rr, input logic [127:0] dd,
                          input logic cc);
        immop = io; imm = im; rot = ro; typ = ty;
        rega = ra; ai = a; r = rr; d = dd; c = cc;
    endtask

    // Directed vector on the 32-bit, 2-stage instance
    task automatic run_vec(input string tag, input logic [31:0] ed,
                           input logic ec);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, ".rdy"}, 128'(ir[0]), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 6) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 128'(lat), 2);
        check({tag, ".d"}, od[0], 128'(ed));
        check({tag, ".c"}, 128'(oc[0]), 128'(ec));
    endtask

    function automatic logic [128:0] ref_model(
        input int w, input logic [127:0] dv, input logic cv,
        input logic io, input logic [7:0] im, input logic [3:0] ro,
        input logic [1:0] ty, input logic ra, input int aimm,
        input int rr);
        logic [127:0] res;
        logic [127:0] iv;
        logic         co;
        int           a;
        res = '0;
        co  = cv;
        iv  = 128'(im);
        if (io) begin
            a = (2 * int'(ro)) % w;
            for (int i = 0; i < w; i++) res[i] = iv[(i + a) % w];
            co = (ro == 4'd0) ? cv : res[w-1];
        end else begin
            a = ra ? rr : (aimm % w);
            if (ra && rr == 0) begin
                for (int i = 0; i < w; i++) res[i] = dv[i];
                co = cv;
            end else if (ty == 2'd0) begin
                if (a == 0) begin
                    for (int i = 0; i < w; i++) res[i] = dv[i];
                    co = cv;
                end else if (a < w) begin
                    for (int i = 0; i < w; i++)
                        if (i >= a) res[i] = dv[i-a];
                    co = dv[w-a];
                end else if (a == w) begin
                    co = dv[0];
                end else begin
                    co = 1'b0;
                end
            end else if (ty != 2'd3) begin
                if (a == 0) a = w;
                if (a < w) begin
                    for (int i = 0; i < w; i++)
                        res[i] = (i + a < w) ? dv[i+a]
                               : (ty == 2'd2 ? dv[w-1] : 1'b0);
                    co = dv[a-1];
                end else if (ty == 2'd2) begin
                    for (int i = 0; i < w; i++) res[i] = dv[w-1];
                    co = dv[w-1];
                end else if (a == w) begin
                    co = dv[w-1];
                end else begin
                    co = 1'b0;
                end
            end else begin
                if (!ra && a == 0) begin
                    for (int i = 0; i < w - 1; i++) res[i] = dv[i+1];
                    res[w-1] = cv;
                    co = dv[0];
                end else begin
                    a = a % w;
                    for (int i = 0; i < w; i++) res[i] = dv[(i + a) % w];
                    co = (a == 0) ? dv[w-1] : dv[a-1];
                end
            end
        end
        return {co, res};
    endfunction

    task automatic set_bp(input int k);
        case (k)
            0: set_in(0, 0, 0, 2'd0, 0, 4, 0, 128'h1, 0);
            1: set_in(0, 0, 0, 2'd1, 0, 31, 0, 128'h80000000, 0);
            2: set_in(0, 0, 0, 2'd2, 0, 1, 0, 128'h80000000, 0);
            3: set_in(0, 0, 0, 2'd3, 0, 4, 0, 128'hF, 0);
            default: set_in(1, 8'h01, 4'd1, 2'd0, 0, 0, 0, 128'h0, 0);
        endcase
    endtask

    logic [31:0]  bp_d [5];
    logic         bp_c [5];
    logic         hv [200];
    logic [128:0] he [3][200];

    initial begin
        int  sent;
        int  got;
        bit  drop_seen;
        bit  prev_stall;
        bit  acc;
        logic [127:0] pd;
        logic pc;

        bp_d = '{32'h10, 32'h1, 32'hC0000000, 32'hF0000000, 32'h40000000};
        bp_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_in(1, 8'hFF, 4'd4, 2'd0, 0, 0, 0, 128'h12345678, 1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst.rdy", 128'(ir[0]), 0);
            check("rst.v", 128'(ov[0]), 0);
            check("rst.d", od[0], 0);
            check("rst.c", 128'(oc[0]), 0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst.none", 128'(ov[0]), 0);
        end

        set_in(1, 8'hFF, 4'd4, 2'd0, 0, 0, 0, 128'h0, 0);
        run_vec("imm.rot4", 32'hFF000000, 1);
        set_in(1, 8'hFF, 4'd0, 2'd0, 0, 0, 0, 128'h0, 1);
        run_vec("imm.rot0", 32'h000000FF, 1);

        set_in(0, 0, 0, 2'd1, 0, 0, 0, 128'h80000001, 1);
        run_vec("a0.lsr", 32'h00000000, 1);
        set_in(0, 0, 0, 2'd2, 0, 0, 0, 128'h80000001, 1);
        run_vec("a0.asr", 32'hFFFFFFFF, 1);
        set_in(0, 0, 0, 2'd3, 0, 0, 0, 128'h80000001, 1);
        run_vec("a0.rrx", 32'hC0000000, 1);
        set_in(0, 0, 0, 2'd0, 0, 0, 0, 128'h80000001, 1);
        run_vec("a0.lsl", 32'h80000001, 1);
        set_in(0, 0, 0, 2'd0, 0, 1, 0, 128'h80000001, 0);
        run_vec("a1.lsl", 32'h00000002, 1);
        set_in(0, 0, 0, 2'd2, 0, 4, 0, 128'h80000000, 1);
        run_vec("a4.asr", 32'hF8000000, 0);

        set_in(0, 0, 0, 2'd0, 1, 0, 32, 128'h3, 0);
        run_vec("r32.lsl", 32'h0, 1);
        set_in(0, 0, 0, 2'd0, 1, 0, 33, 128'h3, 0);
        run_vec("r33.lsl", 32'h0, 0);
        set_in(0, 0, 0, 2'd3, 1, 0, 33, 128'h3, 0);
        run_vec("r33.ror", 32'h80000001, 1);
        set_in(0, 0, 0, 2'd3, 1, 0, 64, 128'h3, 0);
        run_vec("r64.ror", 32'h00000003, 0);
        set_in(0, 0, 0, 2'd0, 1, 0, 0, 128'h3, 1);
        run_vec("r0.lsl", 32'h00000003, 1);

        // Backpressure: out_ready low during cycles 3..6 of the stream
        sent = 0; got = 0; drop_seen = 0; prev_stall = 0;
        pd = '0; pc = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 5);
            if (sent < 5) begin
                set_bp(sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("bp.hold_d", od[0], pd);
                check("bp.hold_c", 128'(oc[0]), 128'(pc));
            end
            if (in_valid && !ir[0] && !drop_seen) begin
                drop_seen = 1;
                check("bp.drop", 128'(sent), 2);
            end
            if (ov[0] && out_ready) begin
                if (got < 5) begin
                    check("bp.d", od[0], 128'(bp_d[got]));
                    check("bp.c", 128'(oc[0]), 128'(bp_c[got]));
                end
                got++;
            end
            prev_stall = ov[0] && !out_ready;
            pd  = od[0];
            pc  = oc[0];
            acc = in_valid && ir[0];
            @(posedge clk);
            if (acc) sent++;
        end
        check("bp.count", 128'(got), 5);
        check("bp.dropseen", 128'(drop_seen), 1);

        // Random sweep over all instances against the model
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            for (int g = 0; g < 6; g++) begin
                int k;
                k = i - ((g % 2 == 0) ? 2 : 1);
                if (k < 0) begin
                    check($sformatf("sw%0d.v", g), 128'(ov[g]), 0);
                end else begin
                    check($sformatf("sw%0d.v@%0d", g, k),
                          128'(ov[g]), 128'(hv[k]));
                    if (hv[k]) begin
                        check($sformatf("sw%0d.d@%0d", g, k),
                              od[g], he[g/2][k][127:0]);
                        check($sformatf("sw%0d.c@%0d", g, k),
                              128'(oc[g]), 128'(he[g/2][k][128]));
                    end
                end
            end
            immop = ($urandom % 4) == 0;
            imm   = 8'($urandom);
            rot   = 4'($urandom);
            typ   = 2'($urandom);
            rega  = 1'($urandom);
            ai    = 8'($urandom);
            r     = ($urandom % 2 == 1) ? 8'($urandom)
                                        : 8'($urandom_range(0, 70));
            d     = {$urandom, $urandom, $urandom, $urandom};
            c     = 1'($urandom);
            in_valid = ($urandom % 5) != 0;
            hv[i] = in_valid;
            he[0][i] = ref_model(32, d, c, immop, imm, rot, typ, rega,
                                 int'(ai), int'(r));
            he[1][i] = ref_model(8, d, c, immop, imm, rot, typ, rega,
                                 int'(ai), int'(r));
            he[2][i] = ref_model(64, d, c, immop, imm, rot, typ, rega,
                                 int'(ai), int'(r));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
